sunsen_i2c_target: RTL and testbench

- I2C target (slave) responder, the far end of the I2C master sequence issued through the APB-driven I2C core.
- Lets the interface board emulate a sun-sensor-style register target on a local bus, for loopback self-test and for ground-support emulation.
- Oversamples SCL/SDA on PCLK and holds an internal register bank of NUM_REGS bytes.
- I2C access: a pointer byte followed by auto-incrementing data bytes. The local side reads and writes the same bank.

---
 rtl/sunsen_i2ct_pkg.sv | 26 ++
 rtl/sunsen_i2ct_sync.sv | 38 +++
 rtl/sunsen_i2c_target.sv | 211 +++++++++++++++++++++
 tb/tb_sunsen_i2c_target.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sunsen_i2ct_pkg.sv
// Shared definitions for the sun-sensor I2C target: FSM states, bus ACK levels,
// default address and the majority vote used by the optional glitch filter.
package sunsen_i2ct_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h48;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sunsen_i2ct_sync.sv
// Two-flop synchroniser for one raw pad line (idles high like an I2C bus line).
// Macro SUNSEN_I2CT_GLITCH_FILTER_EN adds a 3-sample majority filter after it.
module sunsen_i2ct_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  import sunsen_i2ct_pkg::*;

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], d_i};
  end

`ifdef SUNSEN_I2CT_GLITCH_FILTER_EN
  // A one-cycle spike only ever occupies one of the three votes, so it is dropped.
  logic [1:0] win_q;
  logic       filt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      win_q  <= 2'b11;
      filt_q <= 1'b1;
    end else begin
      win_q  <= {win_q[0], sync_q[1]};
      filt_q <= maj3(sync_q[1], win_q[0], win_q[1]);
    end
  end

  assign q_o = filt_q;
`else
  assign q_o = sync_q[1];
`endif

endmodule

// File: rtl/sunsen_i2c_target.sv
// I2C target emulating a sun-sensor register bank: pointer byte then auto-incrementing data.
// Optional input glitch filter enabled by defining SUNSEN_I2CT_GLITCH_FILTER_EN.
module sunsen_i2c_target import sunsen_i2ct_pkg::*; #(
  parameter logic [6:0] TARGET_ADDR = DEFAULT_TARGET_ADDR,
  parameter int         NUM_REGS    = 8,
  parameter int         PW          = $clog2(NUM_REGS)
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          SCL_IN,
  input  logic          SDA_IN,
  output logic          SDA_OE,
  input  logic [PW-1:0] LOC_ADDR,
  output logic [7:0]    LOC_RDATA,
  input  logic          LOC_WE,
  input  logic [7:0]    LOC_WDATA,
  output logic          WR_STROBE,
  output logic [PW-1:0] WR_ADDR,
  output logic          BUSY
);

  localparam logic [3:0] BYTE_BITS = 4'd8;

  logic sclS, sdaS;
  logic sclH_q, sdaH_q;
  logic sclRise_q, sclFall_q, start_q, stop_q, sdaBit_q;

  state_e        state_q, state_d;
  logic [3:0]    bitCnt_q, bitCnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          rw_q, rw_d;
  logic          sdaOe_q, sdaOe_d;
  logic          busy_q, busy_d;
  logic          wrStrobe_q, wrStrobe_d;
  logic [PW-1:0] wrAddr_q, wrAddr_d;
  logic          i2cWe;
  logic [7:0]    bank_q [NUM_REGS];
  logic [7:0]    bankOut;

  sunsen_i2ct_sync u_sync_scl (.clk_i(PCLK), .rst_i(PRESET), .d_i(SCL_IN), .q_o(sclS));
  sunsen_i2ct_sync u_sync_sda (.clk_i(PCLK), .rst_i(PRESET), .d_i(SDA_IN), .q_o(sdaS));

  // Registered edge and bus-condition flags; the FSM only ever sees these one-cycle pulses.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sclH_q    <= 1'b1;
      sdaH_q    <= 1'b1;
      sclRise_q <= 1'b0;
      sclFall_q <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      sdaBit_q  <= 1'b1;
    end else begin
      sclH_q    <= sclS;
      sdaH_q    <= sdaS;
      sclRise_q <= sclS & ~sclH_q;
      sclFall_q <= ~sclS & sclH_q;
      start_q   <= sclS & sclH_q & sdaH_q & ~sdaS;
      stop_q    <= sclS & sclH_q & ~sdaH_q & sdaS;
      sdaBit_q  <= sdaS;
    end
  end

  assign bankOut = bank_q[ptr_q];

  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    sdaOe_d    = sdaOe_q;
    busy_d     = busy_q;
    wrStrobe_d = 1'b0;
    wrAddr_d   = wrAddr_q;
    i2cWe      = 1'b0;

    if (stop_q) begin
      state_d = ST_IDLE;
      sdaOe_d = 1'b0;
      busy_d  = 1'b0;
    end else if (start_q) begin
      state_d  = ST_ADDR;
      bitCnt_d = 4'd0;
      sdaOe_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (sclRise_q && bitCnt_q != BYTE_BITS) begin
            shift_d  = {shift_q[6:0], sdaBit_q};
            bitCnt_d = bitCnt_q + 4'd1;
          end else if (sclFall_q && bitCnt_q == BYTE_BITS) begin
            sdaOe_d = 1'b1;
            if (state_q == ST_ADDR) begin
              if (shift_q[7:1] == TARGET_ADDR) begin
                rw_d    = shift_q[0];
                busy_d  = 1'b1;
                state_d = ST_ADDR_ACK;
              end else begin
                sdaOe_d = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
              end
            end else if (state_q == ST_PTR) begin
              ptr_d   = shift_q[PW-1:0];
              state_d = ST_PTR_ACK;
            end else begin
              i2cWe      = 1'b1;
              wrStrobe_d = 1'b1;
              wrAddr_d   = ptr_q;
              ptr_d      = ptr_q + 1'b1;
              state_d    = ST_WDATA_ACK;
            end
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (sclFall_q) begin
            sdaOe_d  = 1'b0;
            bitCnt_d = 4'd0;
            if (state_q == ST_ADDR_ACK && rw_q) begin
              shift_d = bankOut;
              ptr_d   = ptr_q + 1'b1;
              sdaOe_d = ~bankOut[7];
              state_d = ST_RDATA;
            end else if (state_q == ST_ADDR_ACK) begin
              state_d = ST_PTR;
            end else begin
              state_d = ST_WDATA;
            end
          end
        end
        ST_RDATA: begin
          if (sclRise_q && bitCnt_q != BYTE_BITS) begin
            bitCnt_d = bitCnt_q + 4'd1;
          end else if (sclFall_q) begin
            if (bitCnt_q == BYTE_BITS) begin
              sdaOe_d = 1'b0;
              state_d = ST_RDATA_ACK;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              sdaOe_d = ~shift_q[6];
            end
          end
        end
        // bitCnt is reused as the "master acknowledged" marker: 8 on entry, 0 once ACK is seen.
        ST_RDATA_ACK: begin
          if (sclRise_q) begin
            if (sdaBit_q == I2C_NACK) begin
              sdaOe_d = 1'b0;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end else begin
              bitCnt_d = 4'd0;
            end
          end else if (sclFall_q && bitCnt_q == 4'd0) begin
            shift_d = bankOut;
            ptr_d   = ptr_q + 1'b1;
            sdaOe_d = ~bankOut[7];
            state_d = ST_RDATA;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= ST_IDLE;
      bitCnt_q   <= 4'd0;
      shift_q    <= 8'h00;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      sdaOe_q    <= 1'b0;
      busy_q     <= 1'b0;
      wrStrobe_q <= 1'b0;
      wrAddr_q   <= '0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      sdaOe_q    <= sdaOe_d;
      busy_q     <= busy_d;
      wrStrobe_q <= wrStrobe_d;
      wrAddr_q   <= wrAddr_d;
    end
  end

  // I2C write has priority over a local write to the same register in the same cycle.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= 8'h00;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i2cWe && ptr_q == PW'(i))            bank_q[i] <= shift_q;
        else if (LOC_WE && LOC_ADDR == PW'(i))   bank_q[i] <= LOC_WDATA;
      end
    end
  end

  assign SDA_OE    = sdaOe_q;
  assign BUSY      = busy_q;
  assign WR_STROBE = wrStrobe_q;
  assign WR_ADDR   = wrAddr_q;
  assign LOC_RDATA = bank_q[LOC_ADDR];

endmodule

// File: tb/tb_sunsen_i2c_target.sv
// Directed bench for sunsen_i2c_target: acts as I2C master on a wired-AND SDA line
// and checks bank contents, ACKs, strobes and bus release against hand-computed values.
module tb_sunsen_i2c_target;

  localparam int NUM_REGS = 8;
  localparam int PW       = 3;
`ifdef SUNSEN_I2CT_GLITCH_FILTER_EN
  localparam int LAT_EXTRA = 2;
`else
  localparam int LAT_EXTRA = 0;
`endif

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          scl, sdaM, ignoreOe;
  logic          SDA_IN;
  logic          SDA_OE;
  logic [PW-1:0] LOC_ADDR;
  logic [7:0]    LOC_RDATA;
  logic          LOC_WE;
  logic [7:0]    LOC_WDATA;
  logic          WR_STROBE;
  logic [PW-1:0] WR_ADDR;
  logic          BUSY;

  int vectors     = 0;
  int miscompares = 0;
  int oeCount     = 0;
  int busyCount   = 0;
  logic [PW-1:0] strobeLog[$];
  logic [7:0]    bankModel[NUM_REGS];

  assign SDA_IN = sdaM & (ignoreOe | ~SDA_OE);

  sunsen_i2c_target dut (
    .PCLK(PCLK), .PRESET(PRESET), .SCL_IN(scl), .SDA_IN(SDA_IN), .SDA_OE(SDA_OE),
    .LOC_ADDR(LOC_ADDR), .LOC_RDATA(LOC_RDATA), .LOC_WE(LOC_WE), .LOC_WDATA(LOC_WDATA),
    .WR_STROBE(WR_STROBE), .WR_ADDR(WR_ADDR), .BUSY(BUSY)
  );

  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) begin
    if (SDA_OE) oeCount++;
    if (BUSY) busyCount++;
    if (WR_STROBE) strobeLog.push_back(WR_ADDR);
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic writeBit(input logic b);
    sdaM = b; #40; scl = 1'b1; #80; scl = 1'b0; #40;
  endtask

  task automatic writeBitSpike(input logic b);
    sdaM = b; #40; scl = 1'b1; #40; scl = 1'b0; #10; scl = 1'b1; #30; scl = 1'b0; #40;
  endtask

  task automatic readBit(output logic b);
    sdaM = 1'b1; #40; scl = 1'b1; #40; b = SDA_IN; #40; scl = 1'b0; #40;
  endtask

  task automatic sendByte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) writeBit(d[i]);
    readBit(ack);
  endtask

  task automatic recvByte(output logic [7:0] d, input logic masterAck);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      readBit(b);
      d[i] = b;
    end
    writeBit(masterAck);
  endtask

  task automatic i2cStart();
    @(negedge PCLK);
    sdaM = 1'b0; #40; scl = 1'b0; #40;
  endtask

  task automatic i2cRestart();
    sdaM = 1'b1; #40; scl = 1'b1; #40; sdaM = 1'b0; #40; scl = 1'b0; #40;
  endtask

  task automatic i2cStop();
    sdaM = 1'b0; #40; scl = 1'b1; #40; sdaM = 1'b1; #80;
  endtask

  task automatic locWrite(input logic [PW-1:0] idx, input logic [7:0] d);
    @(negedge PCLK);
    LOC_ADDR = idx; LOC_WDATA = d; LOC_WE = 1'b1;
    @(negedge PCLK);
    LOC_WE = 1'b0;
    bankModel[idx] = d;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    repeat (3) @(negedge PCLK);
    vectors++; if (SDA_OE !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_sda_oe: got %b expected 0", SDA_OE); end
    vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", BUSY); end
    vectors++; if (WR_STROBE !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wr_strobe: got %b expected 0", WR_STROBE); end
    vectors++; if (WR_ADDR !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_wr_addr: got %0d expected 0", WR_ADDR); end
    PRESET = 1'b0;
    repeat (4) @(negedge PCLK);
    for (int i = 0; i < NUM_REGS; i++) begin
      LOC_ADDR = PW'(i); #1;
      vectors++; if (LOC_RDATA !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_bank[%0d]: got %h expected 00", i, LOC_RDATA); end
    end
  endtask

  task automatic test_write();
    logic ack;
    int n0;
    logic [7:0] data [4];
    data[0] = 8'h90; data[1] = 8'h02; data[2] = 8'hA5; data[3] = 8'h3C;
    n0 = strobeLog.size();
    i2cStart();
    for (int k = 0; k < 4; k++) begin
      sendByte(data[k], ack);
      vectors++; if (ack !== 1'b0) begin miscompares++; $display("[TB] FAIL write_ack[%0d]: got %b expected 0", k, ack); end
      if (k == 0) begin
        vectors++; if (BUSY !== 1'b1) begin miscompares++; $display("[TB] FAIL write_busy_on: got %b expected 1", BUSY); end
      end
    end
    i2cStop();
    bankModel[2] = 8'hA5; bankModel[3] = 8'h3C;
    vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("[TB] FAIL write_busy_off: got %b expected 0", BUSY); end
    for (int i = 2; i <= 3; i++) begin
      LOC_ADDR = PW'(i); #1;
      vectors++; if (LOC_RDATA !== bankModel[i]) begin miscompares++; $display("[TB] FAIL write_bank[%0d]: got %h expected %h", i, LOC_RDATA, bankModel[i]); end
    end
    vectors++;
    if (strobeLog.size() - n0 !== 2) begin
      miscompares++; $display("[TB] FAIL write_strobe_count: got %0d expected 2", strobeLog.size() - n0);
    end else begin
      vectors++; if (strobeLog[n0] !== 3'd2) begin miscompares++; $display("[TB] FAIL write_wr_addr0: got %0d expected 2", strobeLog[n0]); end
      vectors++; if (strobeLog[n0+1] !== 3'd3) begin miscompares++; $display("[TB] FAIL write_wr_addr1: got %0d expected 3", strobeLog[n0+1]); end
    end
  endtask

  task automatic test_read_wrap();
    logic ack;
    logic [7:0] d;
    locWrite(3'd7, 8'h11);
    locWrite(3'd0, 8'h22);
    i2cStart();
    sendByte(8'h90, ack);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("[TB] FAIL read_addr_w_ack: got %b expected 0", ack); end
    sendByte(8'h07, ack);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("[TB] FAIL read_ptr_ack: got %b expected 0", ack); end
    i2cRestart();
    sendByte(8'h91, ack);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("[TB] FAIL read_addr_r_ack: got %b expected 0", ack); end
    recvByte(d, 1'b0);
    vectors++; if (d !== 8'h11) begin miscompares++; $display("[TB] FAIL read_byte0: got %h expected 11", d); end
    recvByte(d, 1'b1);
    vectors++; if (d !== 8'h22) begin miscompares++; $display("[TB] FAIL read_byte1_wrap: got %h expected 22", d); end
    vectors++; if (SDA_OE !== 1'b0) begin miscompares++; $display("[TB] FAIL read_oe_after_nack: got %b expected 0", SDA_OE); end
    vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("[TB] FAIL read_busy_after_nack: got %b expected 0", BUSY); end
    i2cStop();
  endtask

  task automatic test_addr_mismatch();
    logic ack;
    int oe0, busy0;
    oe0 = oeCount; busy0 = busyCount;
    i2cStart();
    sendByte(8'h92, ack);
    vectors++; if (ack !== 1'b1) begin miscompares++; $display("[TB] FAIL mismatch_nack: got %b expected 1", ack); end
    i2cStop();
    vectors++; if (oeCount !== oe0) begin miscompares++; $display("[TB] FAIL mismatch_oe_cycles: got %0d expected 0", oeCount - oe0); end
    vectors++; if (busyCount !== busy0) begin miscompares++; $display("[TB] FAIL mismatch_busy_cycles: got %0d expected 0", busyCount - busy0); end
    for (int i = 0; i < NUM_REGS; i++) begin
      LOC_ADDR = PW'(i); #1;
      vectors++; if (LOC_RDATA !== bankModel[i]) begin miscompares++; $display("[TB] FAIL mismatch_bank[%0d]: got %h expected %h", i, LOC_RDATA, bankModel[i]); end
    end
  endtask

  task automatic test_stop_mid_read();
    logic ack, b;
    locWrite(3'd5, 8'h0F);
    i2cStart();
    sendByte(8'h90, ack);
    sendByte(8'h05, ack);
    i2cRestart();
    sendByte(8'h91, ack);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("[TB] FAIL stop_addr_r_ack: got %b expected 0", ack); end
    readBit(b);
    vectors++; if (b !== 1'b0) begin miscompares++; $display("[TB] FAIL stop_bit7: got %b expected 0", b); end
    vectors++; if (SDA_OE !== 1'b1) begin miscompares++; $display("[TB] FAIL stop_oe_driving_bit6: got %b expected 1", SDA_OE); end
    ignoreOe = 1'b1;
    sdaM = 1'b0; scl = 1'b1; #40;
    sdaM = 1'b1;
    repeat (4 + LAT_EXTRA) @(posedge PCLK);
    #1;
    vectors++; if (SDA_OE !== 1'b0) begin miscompares++; $display("[TB] FAIL stop_oe_release: got %b expected 0", SDA_OE); end
    vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("[TB] FAIL stop_busy: got %b expected 0", BUSY); end
    ignoreOe = 1'b0;
    #40;
    i2cStart();
    sendByte(8'h90, ack);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("[TB] FAIL stop_next_ack: got %b expected 0", ack); end
    vectors++; if (BUSY !== 1'b1) begin miscompares++; $display("[TB] FAIL stop_next_busy: got %b expected 1", BUSY); end
    i2cStop();
  endtask

  task automatic test_collision();
    logic ack, seen;
    i2cStart();
    sendByte(8'h90, ack);
    sendByte(8'h03, ack);
    seen = 1'b0;
    fork
      sendByte(8'h99, ack);
      begin
        LOC_ADDR = 3'd3; LOC_WDATA = 8'h77; LOC_WE = 1'b1;
        for (int k = 0; k < 400; k++) begin
          @(posedge PCLK); #1;
          if (WR_STROBE) begin seen = 1'b1; break; end
        end
        LOC_WE = 1'b0;
      end
    join
    i2cStop();
    bankModel[3] = 8'h99;
    vectors++; if (seen !== 1'b1) begin miscompares++; $display("[TB] FAIL collision_strobe: got %b expected 1", seen); end
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("[TB] FAIL collision_ack: got %b expected 0", ack); end
    LOC_ADDR = 3'd3; #1;
    vectors++; if (LOC_RDATA !== 8'h99) begin miscompares++; $display("[TB] FAIL collision_bank3: got %h expected 99", LOC_RDATA); end
  endtask

`ifdef SUNSEN_I2CT_GLITCH_FILTER_EN
  task automatic test_glitch();
    logic ack;
    int n0;
    logic [7:0] d;
    d = 8'hC3;
    n0 = strobeLog.size();
    i2cStart();
    sendByte(8'h90, ack);
    sendByte(8'h04, ack);
    for (int i = 7; i >= 0; i--) begin
      if (i == 3) writeBitSpike(d[i]);
      else        writeBit(d[i]);
    end
    readBit(ack);
    i2cStop();
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("[TB] FAIL glitch_ack: got %b expected 0", ack); end
    LOC_ADDR = 3'd4; #1;
    vectors++; if (LOC_RDATA !== 8'hC3) begin miscompares++; $display("[TB] FAIL glitch_bank4: got %h expected c3", LOC_RDATA); end
    vectors++; if (strobeLog.size() - n0 !== 1) begin miscompares++; $display("[TB] FAIL glitch_strobe_count: got %0d expected 1", strobeLog.size() - n0); end
  endtask
`endif

  initial begin
    scl = 1'b1; sdaM = 1'b1; ignoreOe = 1'b0;
    LOC_ADDR = '0; LOC_WE = 1'b0; LOC_WDATA = 8'h00;
    PRESET = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) bankModel[i] = 8'h00;
    $display("[TB] starting sunsen_i2c_target bench");
    test_reset();
    test_write();
    test_read_wrap();
    test_addr_mismatch();
    test_stop_mid_read();
    test_collision();
`ifdef SUNSEN_I2CT_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
